alu_cmd_sequencer: RTL

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for a registered downstream ALU: a command FIFO, a credit-gated
// issue stage, a two-stage in-flight tracker and an in-order result buffer.
module alu_cmd_sequencer #(
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [2:0]  cmd_op,
    output logic        alu_en,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    input  logic [15:0] alu_result,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_err,
    output logic        busy
);

    localparam int CPW = $clog2(CMD_DEPTH);
    localparam int CCW = CPW + 1;
    localparam int RPW = $clog2(RES_DEPTH);
    localparam int RCW = RPW + 1;
    localparam logic [CCW-1:0] CMD_LIMIT = CCW'(CMD_DEPTH);
    localparam logic [RCW:0]   RES_LIMIT = (RCW + 1)'(RES_DEPTH);

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
    } cmd_t;

    cmd_t            cmd_mem [CMD_DEPTH];
    logic [CPW-1:0]  cmd_wr_ptr;
    logic [CPW-1:0]  cmd_rd_ptr;
    logic [CCW-1:0]  cmd_count;

    logic [15:0]     res_mem     [RES_DEPTH];
    logic            res_err_mem [RES_DEPTH];
    logic [RPW-1:0]  res_wr_ptr;
    logic [RPW-1:0]  res_rd_ptr;
    logic [RCW-1:0]  res_count;

    logic            s1_valid, s1_err;
    logic            s2_valid, s2_err;

    cmd_t            head;
    logic            head_illegal;
    logic [RCW:0]    credit_used;
    logic            push, issue, capture, pop;

    assign head         = cmd_mem[cmd_rd_ptr];
    assign head_illegal = head.op[2] & head.op[1];

    // Results already buffered plus those still in flight must fit, so capture never overflows.
    assign credit_used = {1'b0, res_count} + (RCW + 1)'(s1_valid) + (RCW + 1)'(s2_valid);

    assign cmd_ready = ~rst & (cmd_count < CMD_LIMIT);
    assign push      = cmd_valid & cmd_ready;
    assign issue     = (cmd_count != '0) && (credit_used < RES_LIMIT);
    assign capture   = s2_valid;
    assign res_valid = (res_count != '0);
    assign pop       = res_valid & res_ready;
    assign busy      = (cmd_count != '0) | s1_valid | s2_valid | res_valid;

    // The buffer storage is not reset, so the head is masked until an entry is present.
    assign res_data  = res_valid ? res_mem[res_rd_ptr]     : '0;
    assign res_err   = res_valid ? res_err_mem[res_rd_ptr] : 1'b0;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            cmd_count  <= '0;
            res_wr_ptr <= '0;
            res_rd_ptr <= '0;
            res_count  <= '0;
            s1_valid   <= 1'b0;
            s1_err     <= 1'b0;
            s2_valid   <= 1'b0;
            s2_err     <= 1'b0;
            alu_en     <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
        end else begin
            if (push)
                cmd_wr_ptr <= cmd_wr_ptr + CPW'(1);
            if (issue)
                cmd_rd_ptr <= cmd_rd_ptr + CPW'(1);
            if (push && !issue)
                cmd_count <= cmd_count + CCW'(1);
            else if (!push && issue)
                cmd_count <= cmd_count - CCW'(1);

            s1_valid <= issue;
            s1_err   <= issue & head_illegal;
            s2_valid <= s1_valid;
            s2_err   <= s1_err;

            alu_en <= issue & ~head_illegal;
            if (issue && !head_illegal) begin
                alu_a  <= head.a;
                alu_b  <= head.b;
                alu_op <= head.op;
            end

            if (capture)
                res_wr_ptr <= res_wr_ptr + RPW'(1);
            if (pop)
                res_rd_ptr <= res_rd_ptr + RPW'(1);
            if (capture && !pop)
                res_count <= res_count + RCW'(1);
            else if (!capture && pop)
                res_count <= res_count - RCW'(1);
        end
    end

    // NOTE: storage arrays carry no reset; validity is tracked by the counts and pointers.
    always_ff @(posedge CLK) begin
        if (push)
            cmd_mem[cmd_wr_ptr] <= '{a: cmd_a, b: cmd_b, op: cmd_op};
        if (capture) begin
            res_mem[res_wr_ptr]     <= s2_err ? 16'h0000 : alu_result;
            res_err_mem[res_wr_ptr] <= s2_err;
        end
    end

endmodule
